// File: rtl/display_sequencer.sv
// Item scheduler for the three-digit seven-segment display: dwell-timed RUN, manual step in PAUSE.
// Optional macro DISPLAY_SEQ_PINGPONG_EN selects ping-pong ordering instead of wrap-around per dir.
module display_sequencer #(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned NUM_ITEMS    = 4,
  parameter int unsigned SEL_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             step,
  input  logic             dir,
  output logic [SEL_W-1:0] select,
  output logic             tick,
  output logic             paused
);

  localparam int unsigned      CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ITEMS - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic             tick_q, tick_d;
  logic             paused_q, paused_d;
  logic             step_q, step_d;
  logic             step_edge_s;
  logic             term_s;
  logic             advance_s;

`ifdef DISPLAY_SEQ_PINGPONG_EN
  localparam logic [SEL_W-1:0] SEL_PENULT = SEL_W'(NUM_ITEMS - 2);

  logic down_q, down_d;
  logic unused_dir_s;

  assign unused_dir_s = dir;

  // Returns {new_down, new_index}; the direction flips when an end of the range is reached.
  function automatic logic [SEL_W:0] pingpong_next(input logic [SEL_W-1:0] cur, input logic down);
    logic [SEL_W:0] res;
    if (down) begin
      if (cur == SEL_ZERO) begin
        res = {1'b0, SEL_ONE};
      end else begin
        res = {1'b1, cur - SEL_ONE};
      end
    end else begin
      if (cur >= SEL_LAST) begin
        res = {1'b1, SEL_PENULT};
      end else begin
        res = {1'b0, cur + SEL_ONE};
      end
    end
    return res;
  endfunction
`else
  // Wrap-around successor; never yields an index at or above NUM_ITEMS.
  function automatic logic [SEL_W-1:0] wrap_next(input logic [SEL_W-1:0] cur, input logic down);
    logic [SEL_W-1:0] nxt;
    if (down) begin
      if (cur == SEL_ZERO) begin
        nxt = SEL_LAST;
      end else begin
        nxt = cur - SEL_ONE;
      end
    end else begin
      if (cur >= SEL_LAST) begin
        nxt = SEL_ZERO;
      end else begin
        nxt = cur + SEL_ONE;
      end
    end
    return nxt;
  endfunction
`endif

  // Next-state, dwell counter and advance decision.
  always_comb begin
    step_edge_s = step & ~step_q;
    term_s      = (cnt_q == CNT_LAST);
    state_d     = state_q;
    cnt_d       = cnt_q;
    advance_s   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Terminal count and a step edge in the same cycle still make one advance.
        advance_s = term_s | step_edge_s;
        if (advance_s) begin
          cnt_d = CNT_ZERO;
        end else if (run_en) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        if (run_en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        advance_s = step_edge_s;
        if (run_en) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_PAUSE;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d   = ST_PAUSE;
        cnt_d     = CNT_ZERO;
        advance_s = 1'b0;
      end
    endcase
  end

  // Item index update on an advance, plus the registered status outputs.
  always_comb begin
    select_d = select_q;
`ifdef DISPLAY_SEQ_PINGPONG_EN
    down_d = down_q;
    if (advance_s) begin
      {down_d, select_d} = pingpong_next(select_q, down_q);
    end else begin
      down_d   = down_q;
      select_d = select_q;
    end
`else
    if (advance_s) begin
      select_d = wrap_next(select_q, dir);
    end else begin
      select_d = select_q;
    end
`endif
    tick_d   = advance_s;
    paused_d = (state_d == ST_PAUSE);
    step_d   = step;
  end

  // State register; step_q resets high so a step held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PAUSE;
      cnt_q    <= CNT_ZERO;
      select_q <= SEL_ZERO;
      tick_q   <= 1'b0;
      paused_q <= 1'b1;
      step_q   <= 1'b1;
`ifdef DISPLAY_SEQ_PINGPONG_EN
      down_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      tick_q   <= tick_d;
      paused_q <= paused_d;
      step_q   <= step_d;
`ifdef DISPLAY_SEQ_PINGPONG_EN
      down_q   <= down_d;
`endif
    end
  end

  assign select = select_q;
  assign tick   = tick_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer: stimulus queues expected advances, a monitor checks each tick.
module tb_display_sequencer;

  localparam int DW = 4;
  localparam int NI = 4;
  localparam int SW = 2;

  typedef struct {
    int sel;
    int at;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_en;
  logic          step;
  logic          dir;
  logic [SW-1:0] select;
  logic          tick;
  logic          paused;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   c, p, e, f;
  int   pp_seq[7] = '{1, 2, 3, 2, 1, 0, 1};

  display_sequencer #(
    .DWELL_CYCLES(DW),
    .NUM_ITEMS   (NI),
    .SEL_W       (SW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .run_en(run_en),
    .step  (step),
    .dir   (dir),
    .select(select),
    .tick  (tick),
    .paused(paused)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_adv(input int sel, input int at);
    exp_t x;
    x.sel = sel;
    x.at  = at;
    exp_q.push_back(x);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every tick must match the oldest queued advance in value and cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("select_range", (select < NI) ? 32'd1 : 32'd0, 32'd1);
      if (tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick: select=%0d at cycle %0d, no advance expected", select, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("adv_select", {30'd0, select}, mon_e.sel);
          check("adv_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    run_en = 1'b0;
    step   = 1'b1;
    dir    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_select", {30'd0, select}, 32'd0);
    check("rst_paused", {31'd0, paused}, 32'd1);
    check("rst_tick", {31'd0, tick}, 32'd0);
    step = 1'b0;
    @(negedge clk);

`ifdef DISPLAY_SEQ_PINGPONG_EN
    c      = cyc;
    run_en = 1'b1;
    for (int k = 0; k < 7; k++) expect_adv(pp_seq[k], c + 5 + 4 * k);
    @(negedge clk);
    check("run_paused", {31'd0, paused}, 32'd0);
    wait_until(c + 13);
    dir = 1'b1;
    wait_until(c + 21);
    dir = 1'b0;
    wait_until(c + 31);
    run_en = 1'b0;
`else
    // Auto advance upward, then downward through the wrap at 0.
    c      = cyc;
    run_en = 1'b1;
    dir    = 1'b0;
    expect_adv(1, c + 5);
    expect_adv(2, c + 9);
    expect_adv(3, c + 13);
    expect_adv(0, c + 17);
    expect_adv(1, c + 21);
    expect_adv(0, c + 25);
    expect_adv(3, c + 29);
    expect_adv(2, c + 33);
    @(negedge clk);
    check("run_paused", {31'd0, paused}, 32'd0);
    wait_until(c + 22);
    dir = 1'b1;
    wait_until(c + 35);
    run_en = 1'b0;
    dir    = 1'b0;
    @(negedge clk);
    check("pause_paused", {31'd0, paused}, 32'd1);
    check("pause_select", {30'd0, select}, 32'd2);

    // Manual steps of 1, 3 and 5 cycles: one advance each.
    p    = cyc;
    step = 1'b1;
    expect_adv(3, p + 1);
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    p    = cyc;
    step = 1'b1;
    expect_adv(0, p + 1);
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    p    = cyc;
    step = 1'b1;
    expect_adv(1, p + 1);
    repeat (5) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    check("steps_paused", {31'd0, paused}, 32'd1);

    // Re-entry to RUN, step aligned with terminal count, step mid-dwell.
    e      = cyc;
    run_en = 1'b1;
    expect_adv(2, e + 5);
    expect_adv(3, e + 9);
    expect_adv(0, e + 13);
    expect_adv(1, e + 15);
    expect_adv(2, e + 19);
    expect_adv(3, e + 23);
    wait_until(e + 8);
    step = 1'b1;
    wait_until(e + 10);
    step = 1'b0;
    wait_until(e + 14);
    step = 1'b1;
    wait_until(e + 15);
    step = 1'b0;
    // run_en drops in the terminal-count cycle: advance, then pause.
    wait_until(e + 22);
    run_en = 1'b0;
    @(negedge clk);
    check("fall_paused", {31'd0, paused}, 32'd1);
    repeat (6) @(negedge clk);

    // Reset in the middle of a dwell.
    f      = cyc;
    run_en = 1'b1;
    wait_until(f + 3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_select", {30'd0, select}, 32'd0);
    check("mid_rst_paused", {31'd0, paused}, 32'd1);
    check("mid_rst_tick", {31'd0, tick}, 32'd0);
    rst = 1'b0;
    expect_adv(1, f + 9);
    @(negedge clk);
    check("post_rst_paused", {31'd0, paused}, 32'd0);
    wait_until(f + 10);
    run_en = 1'b0;
`endif

    repeat (6) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Scheduler that drives the 2-bit `select` input of the three-digit seven-segment number display.
- Steps through the display's items automatically on a programmable dwell timer, or manually on a step input while paused.
- Sits between board switches/buttons and the display block; its `select` output wires directly to the display's `select` input.

Parameters:
- DWELL_CYCLES, 50000000, clock cycles each item is shown in RUN (1 s at 50 MHz); must be ≥ 2.
- NUM_ITEMS, 4, number of display items cycled, indices 0..NUM_ITEMS-1; 2 ≤ NUM_ITEMS ≤ 2**SEL_W.
- SEL_W, 2, width of select.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- run_en, input, 1, 1 = auto-advance (RUN), 0 = hold (PAUSE); level, already synchronous.
- step, input, 1, manual advance request; rising-edge detected internally; already synchronous/debounced.
- dir, input, 1, 0 = advance upward (index+1), 1 = downward (index-1).
- select, output, SEL_W, current item index to the display; registered.
- tick, output, 1, one-cycle pulse in the cycle select takes a new value.
- paused, output, 1, 1 while FSM is in PAUSE.

Behaviour:
- Reset (rst=1 at clock edge):
  - select=0, tick=0, state=PAUSE, paused=1, dwell counter=0.
  - step_q (previous step sample) = 1, so step held high through reset produces no edge.
- State encoding: RUN, PAUSE. paused is registered: paused = (state==PAUSE).
- Dwell counter: width $clog2(DWELL_CYCLES); counts 0..DWELL_CYCLES-1 in RUN only; holds in PAUSE.
- step_edge = step & ~step_q; step_q <= step every cycle.
- Transitions:
  - PAUSE→RUN when run_en=1; counter cleared on entry.
  - RUN→PAUSE when run_en=0; counter holds its value, but is cleared on the next PAUSE→RUN anyway.
- Advance event:
  - RUN: counter == DWELL_CYCLES-1, or step_edge.
  - PAUSE: step_edge only.
  - On advance: select <= next(select), counter <= 0, tick <= 1. Otherwise tick <= 0.
- Simultaneous terminal count and step_edge → exactly one advance.
- next() is wrap-around:
  - dir=0: NUM_ITEMS-1 → 0.
  - dir=1: 0 → NUM_ITEMS-1.
  - Never outputs an index ≥ NUM_ITEMS.
- Latency:
  - select and tick update on the same edge as the advance condition is sampled, so in RUN select changes every DWELL_CYCLES cycles exactly.
  - step_edge → select changes at the edge following the cycle step was first sampled high.
- run_en falling in the same cycle as terminal count: the advance still happens, then PAUSE.
- dir changes take effect at the next advance only.
- Mid-operation rst overrides everything; state returns to reset values on that edge.

Optional Feature:
- Macro: DISPLAY_SEQ_PINGPONG_EN
- Defined:
  - Ping-pong order using an internal direction register (reset 0 = up); the dir input is ignored.
  - At index NUM_ITEMS-1 going up, the advance flips direction and selects NUM_ITEMS-2.
  - At index 0 going down, the advance flips direction and selects 1.
  - With NUM_ITEMS=4 the sequence is 0,1,2,3,2,1,0,1...
- Undefined:
  - Wrap-around per dir as above.
  - No direction register is synthesized.

Test Plan (DWELL_CYCLES=4, NUM_ITEMS=4):
- rst=1 for 2 cycles with step=1, run_en=0, then rst=0 → select=0, paused=1, tick never asserts.
- run_en=1, dir=0 after reset → paused=0 one cycle later; select goes 1,2,3,0,1 with exactly 4 cycles between changes; tick high one cycle at each change.
- run_en=1, dir=1 → from select=0 next value 3, then 2; no index ≥ 4 ever appears.
- run_en=0 with select=2 mid-dwell, then step pulses of 1, 3 and 5 cycles → select 3, 0, 1 (one advance per pulse); counter frozen; run_en=1 → next auto advance exactly 4 cycles after re-entry.
- In RUN, step rising edge aligned with terminal count → select advances by exactly 1; tick is a single-cycle pulse.
- With DISPLAY_SEQ_PINGPONG_EN defined, run_en=1 for 28 cycles → select sequence 0,1,2,3,2,1,0,1; dir toggled mid-run has no effect.
